// File: rtl/tinyalu_cmd_driver.sv
// TinyALU command driver: buffers ALU commands in a small FIFO, sequences the
// ALU pins one command at a time, waits for done with a timeout, and returns
// each result through a valid/ready response port.
module tinyalu_cmd_driver #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    parameter int RST_CYC = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [DATA_W-1:0]            cmd_a,
    input  logic [DATA_W-1:0]            cmd_b,
    input  logic [2:0]                   cmd_op,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    output logic [2:0]                   alu_op,
    output logic                         alu_start,
    output logic                         alu_reset_n,
    input  logic                         alu_done,
    input  logic [2*DATA_W-1:0]          alu_result,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [2*DATA_W-1:0]          resp_result,
    output logic [2:0]                   resp_op,
    output logic                         resp_err,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT+1);
    localparam int RW = $clog2(RST_CYC+1);
    localparam int EW = 3 + 2*DATA_W;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    typedef enum logic [2:0] {IDLE, EXEC, WAIT, RSTL, RESP} state_t;

    state_t                state, state_nxt;
    logic [EW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  push, pop;
    logic [DATA_W-1:0]     head_a, head_b;
    logic [2:0]            head_op;

    logic [DATA_W-1:0]     alu_a_nxt, alu_b_nxt;
    logic [2:0]            alu_op_nxt, op_q, op_nxt;
    logic                  alu_start_nxt, alu_reset_n_nxt;
    logic                  resp_valid_nxt, resp_err_nxt;
    logic [2*DATA_W-1:0]   resp_result_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic [RW-1:0]         rcnt, rcnt_nxt;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign cmd_ready  = (count != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign {head_op, head_a, head_b} = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);
    assign resp_op    = op_q;

    // Command storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state and next-pin logic; every pin is registered below.
    always_comb begin
        state_nxt       = state;
        alu_a_nxt       = alu_a;
        alu_b_nxt       = alu_b;
        alu_op_nxt      = alu_op;
        alu_start_nxt   = alu_start;
        alu_reset_n_nxt = alu_reset_n;
        resp_valid_nxt  = resp_valid;
        resp_result_nxt = resp_result;
        resp_err_nxt    = resp_err;
        op_nxt          = op_q;
        timer_nxt       = timer;
        rcnt_nxt        = rcnt;
        case (state)
            IDLE: begin
                alu_reset_n_nxt = 1'b1;
                if (pop) begin
                    op_nxt          = head_op;
                    resp_result_nxt = '0;
                    resp_err_nxt    = 1'b0;
                    case (head_op)
                        OP_NOP, OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                            alu_a_nxt     = head_a;
                            alu_b_nxt     = head_b;
                            alu_op_nxt    = head_op;
                            alu_start_nxt = 1'b1;
                            state_nxt     = EXEC;
                        end
                        OP_RST: begin
                            alu_op_nxt      = OP_RST;
                            alu_start_nxt   = 1'b0;
                            alu_reset_n_nxt = 1'b0;
                            rcnt_nxt        = '0;
                            state_nxt       = RSTL;
                        end
                        default: begin
                            resp_err_nxt   = 1'b1;
                            resp_valid_nxt = 1'b1;
                            state_nxt      = RESP;
                        end
                    endcase
                end
            end
            EXEC: begin
                timer_nxt = '0;
                if (op_q == OP_NOP) begin
                    alu_start_nxt  = 1'b0;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = RESP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (alu_done) begin
                    resp_result_nxt = alu_result;
                    alu_start_nxt   = 1'b0;
                    resp_valid_nxt  = 1'b1;
                    state_nxt       = RESP;
                end else if (timer == TW'(TIMEOUT-1)) begin
                    alu_start_nxt   = 1'b0;
                    resp_err_nxt    = 1'b1;
                    resp_result_nxt = '0;
                    resp_valid_nxt  = 1'b1;
                    state_nxt       = RESP;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            RSTL: begin
                if (rcnt == RW'(RST_CYC-1)) begin
                    alu_reset_n_nxt = 1'b1;
                    resp_result_nxt = '0;
                    resp_valid_nxt  = 1'b1;
                    state_nxt       = RESP;
                end else begin
                    rcnt_nxt = rcnt + RW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and pin registers; reset aborts any command without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            alu_start   <= 1'b0;
            alu_reset_n <= 1'b0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            op_q        <= '0;
            timer       <= '0;
            rcnt        <= '0;
        end else begin
            state       <= state_nxt;
            alu_a       <= alu_a_nxt;
            alu_b       <= alu_b_nxt;
            alu_op      <= alu_op_nxt;
            alu_start   <= alu_start_nxt;
            alu_reset_n <= alu_reset_n_nxt;
            resp_valid  <= resp_valid_nxt;
            resp_result <= resp_result_nxt;
            resp_err    <= resp_err_nxt;
            op_q        <= op_nxt;
            timer       <= timer_nxt;
            rcnt        <= rcnt_nxt;
        end
    end

endmodule
